irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Multi-source interrupt controller placed in front of the core's interrupt-injection sequencer.
- Latches per-source pending bits from level or edge sources and applies an enable mask.
- Selects one source by fixed priority and drives the single irq request line, with a registered ISR vector and source id.
- Tracks the irq/irq_ack and eret_ack handshakes so exactly one interrupt is in service at a time; nesting is not supported.
- Configured through a small register port from the peripheral bus.

Parameters:
- NUM_SRC, 8: number of interrupt sources; legal range 1..16.
- VEC_BASE, 32'h0000_0100: ISR vector for source 0.
- VEC_STRIDE, 4: byte spacing between successive source vectors.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- irq_src  in  NUM_SRC  raw interrupt lines, already synchronous to clk.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  config register select.
- cfg_wdata  in  16  config write data; bits above NUM_SRC are ignored.
- cfg_rdata  out  16  config read data, combinational from cfg_addr.
- irq  out  1  request to the injection sequencer.
- irq_ack  in  1  sequencer has entered the ISR.
- eret_ack  in  1  sequencer has completed the return sequence.
- irq_id  out  4  id of the granted or in-service source.
- isr_vector  out  32  VEC_BASE + irq_id*VEC_STRIDE, registered.
- irq_active  out  1  an ISR is in service.

Behaviour:
- Reset: synchronous, active-high; one clock, clk.
- Values at reset:
  - state=IDLE; irq=0; irq_active=0; irq_id=0; isr_vector=VEC_BASE.
  - en_mask=0; edge_sel=0; pending=0; src_q=0.
- Config registers (read/write):
  - addr0: en_mask.
  - addr1: edge_sel (1 = rising-edge source).
  - addr2: pending. Read returns the pending bits. Writing 1 to a bit sets it (software trigger); writing 0 has no effect.
  - addr3: read-only status {11'b0, irq_active, irq_id}. Writes are ignored.
- Pending logic:
  - src_q holds irq_src delayed by one clock.
  - Edge source: pending bit set when irq_src & ~src_q. Cleared in the cycle irq_ack is seen in REQ, for the granted id only.
  - Level source: pending bit = irq_src OR a software-set bit. The software-set part clears on ack exactly as for an edge source.
  - A set and a clear of the same bit in the same cycle: set wins.
- Candidates: cand = pending & en_mask. The winner is the lowest-index set bit.
- State machine:
  - IDLE:
    - If cand is nonzero, go to REQ. Latch irq_id = winner and isr_vector.
    - Otherwise stay in IDLE.
  - REQ:
    - irq=1. irq_id is frozen: a later, higher-priority source does not preempt it.
    - On irq_ack, go to ACTIVE: irq=0, irq_active=1, clear the granted pending bit.
    - If the granted source drops or is masked while in REQ, the request still stands until ack, because the sequencer may already have committed.
  - ACTIVE:
    - irq_active=1; all new requests are held pending.
    - On eret_ack, go to IDLE with irq_active=0.
- irq is driven from a registered state decode and rises the cycle after the IDLE→REQ transition.
- Latency: a source edge at cycle N gives pending at N+1, and irq=1 with a valid irq_id and isr_vector at N+2.
- After eret_ack, the next grant is possible at the earliest 2 cycles later (IDLE evaluation, then irq).
- Handshake faults:
  - irq_ack outside REQ is ignored.
  - eret_ack outside ACTIVE is ignored.
  - irq_ack and eret_ack in the same cycle follow the current-state rule only.
- Mask changes while ACTIVE take effect at the next IDLE evaluation.
- rst asserted mid-ISR returns to IDLE and clears all pending state; there is no acknowledge toward the sequencer.

Decomposition:
- Shared package irq_pkg holds:
  - state encodings IDLE=2'b00, REQ=2'b01, ACTIVE=2'b10;
  - config address constants CFG_EN=0, CFG_EDGE=1, CFG_PEND=2, CFG_STAT=3;
  - the default VEC_BASE.
- One natural sub-module, irq_prio_enc: a combinational fixed-priority encoder producing {valid, id[3:0]} from an NUM_SRC-bit vector.

Test Plan:
- Set en_mask=8'hFF and edge_sel=8'h01, then pulse irq_src[0] at cycle N → pending[0]=1 at N+1; irq=1, irq_id=0, isr_vector=32'h100 at N+2. Pulse irq_ack → irq=0, irq_active=1, pending[0]=0.
- Raise level sources 3 and 5 together → irq_id=3, isr_vector=32'h10C. After irq_ack then eret_ack, the next grant is irq_id=5, isr_vector=32'h114.
- In REQ for id 4, raise source 1 → irq_id stays 4 until ack. Source 1 is granted only after eret_ack.
- Edge source 2 re-pulses in the same cycle as irq_ack for id 2 → pending[2] stays 1. A second grant of id 2 follows the eret_ack.
- en_mask=0 with a raw edge on source 6 → irq stays 0 and pending[6]=1. Writing en_mask=8'h40 → irq=1, irq_id=6 within 2 cycles.
- Assert rst while ACTIVE with pending=8'h0A → next cycle state=IDLE, irq_active=0, pending=0, irq=0. A stray eret_ack afterwards is ignored.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt arbiter: FSM encodings,
// config register map and the ISR vector helper.
package irq_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] REQ    = 2'b01;
  localparam logic [1:0] ACTIVE = 2'b10;

  localparam logic [1:0] CFG_EN   = 2'd0;
  localparam logic [1:0] CFG_EDGE = 2'd1;
  localparam logic [1:0] CFG_PEND = 2'd2;
  localparam logic [1:0] CFG_STAT = 2'd3;

  localparam logic [31:0] VEC_BASE_DEF = 32'h0000_0100;

  function automatic logic [31:0] vec_of(
    input logic [31:0] base,
    input logic [3:0]  id,
    input int          stride
  );
    return base + 32'(id) * 32'(stride);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, lowest index wins.
// Ports: req (N bits) -> valid, id[3:0].
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   id
);

  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = 4'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter with one-in-service handshake.
// Ports: clk/rst, irq_src, cfg_* bus, irq/irq_ack/eret_ack, irq_id, isr_vector, irq_active.
import irq_pkg::*;

module irq_arbiter #(
  parameter int          NUM_SRC    = 8,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               irq,
  input  logic               irq_ack,
  input  logic               eret_ack,
  output logic [3:0]         irq_id,
  output logic [31:0]        isr_vector,
  output logic               irq_active
);

  logic [1:0]         state;
  logic [1:0]         state_n;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] en_mask;
  logic [NUM_SRC-1:0] edge_sel;
  logic               irq_q;
  logic               active_q;
  logic [3:0]         id_q;
  logic [31:0]        vec_q;

  logic [NUM_SRC-1:0] wr;
  logic [NUM_SRC-1:0] edge_set;
  logic [NUM_SRC-1:0] sw_set;
  logic [NUM_SRC-1:0] clr_v;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] cand;
  logic               ack_ok;
  logic               win_v;
  logic [3:0]         win_id;
  logic               unused_wdata;

  assign wr           = cfg_wdata[NUM_SRC-1:0];
  assign unused_wdata = &{1'b0, cfg_wdata};

  // pend_q holds latched edges and software sets; level
  // sources contribute through src_q so every source sees
  // the same one-cycle pending latency.
  assign edge_set = irq_src & ~src_q & edge_sel;
  assign sw_set   = (cfg_we && cfg_addr == CFG_PEND) ? wr : '0;
  assign ack_ok   = (state == REQ) && irq_ack;
  assign clr_v    = ack_ok ? (NUM_SRC'(1) << id_q) : '0;
  assign pending  = pend_q | (src_q & ~edge_sel);
  assign cand     = pending & en_mask;

  irq_prio_enc #(
    .N(NUM_SRC)
  ) u_enc (
    .req  (cand),
    .valid(win_v),
    .id   (win_id)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (win_v)    state_n = REQ;
      REQ:     if (irq_ack)  state_n = ACTIVE;
      ACTIVE:  if (eret_ack) state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      irq_q    <= 1'b0;
      active_q <= 1'b0;
      id_q     <= '0;
      vec_q    <= VEC_BASE;
      src_q    <= '0;
      pend_q   <= '0;
      en_mask  <= '0;
      edge_sel <= '0;
    end else begin
      state    <= state_n;
      irq_q    <= (state_n == REQ);
      active_q <= (state_n == ACTIVE);
      src_q    <= irq_src;
      // set wins over the ack clear of the same bit
      pend_q   <= (pend_q & ~clr_v) | edge_set | sw_set;
      if (state == IDLE && win_v) begin
        id_q  <= win_id;
        vec_q <= vec_of(VEC_BASE, win_id, VEC_STRIDE);
      end
      if (cfg_we && cfg_addr == CFG_EN)   en_mask  <= wr;
      if (cfg_we && cfg_addr == CFG_EDGE) edge_sel <= wr;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_EN:   cfg_rdata = 16'(en_mask);
      CFG_EDGE: cfg_rdata = 16'(edge_sel);
      CFG_PEND: cfg_rdata = 16'(pending);
      CFG_STAT: cfg_rdata = {11'b0, active_q, id_q};
      default:  cfg_rdata = '0;
    endcase
  end

  assign irq        = irq_q;
  assign irq_active = active_q;
  assign irq_id     = id_q;
  assign isr_vector = vec_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter.
// Drives/samples 1ns after each rising edge.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        irq;
  logic        irq_ack;
  logic        eret_ack;
  logic [3:0]  irq_id;
  logic [31:0] isr_vector;
  logic        irq_active;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  irq_arbiter #(
    .NUM_SRC(8),
    .VEC_BASE(32'h0000_0100),
    .VEC_STRIDE(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .eret_ack  (eret_ack),
    .irq_id    (irq_id),
    .isr_vector(isr_vector),
    .irq_active(irq_active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic grant(input string tag, input logic [3:0] id,
                       input logic [31:0] vec);
    chk({tag, "_irq"}, 32'(irq), 1);
    chk({tag, "_id"}, 32'(irq_id), 32'(id));
    chk({tag, "_vec"}, isr_vector, vec);
  endtask

  logic [15:0] d;

  initial begin
    rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; irq_ack = 1'b0; eret_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_active", 32'(irq_active), 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_vec", isr_vector, 32'h100);
    rd(2'd0, d); chk("rst_en", 32'(d), 0);
    rd(2'd1, d); chk("rst_edge", 32'(d), 0);
    rd(2'd2, d); chk("rst_pend", 32'(d), 0);
    rd(2'd3, d); chk("rst_stat", 32'(d), 0);

    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("stray_ack", 32'(irq_active), 0);

    // T1: edge source 0 latency
    wr(2'd0, 16'h00FF);
    wr(2'd1, 16'h0001);
    rd(2'd0, d); chk("en_rd", 32'(d), 32'hFF);
    rd(2'd1, d); chk("edge_rd", 32'(d), 32'h01);
    irq_src = 8'h01;
    step();
    irq_src = 8'h00;
    rd(2'd2, d); chk("t1_pend", 32'(d), 32'h01);
    chk("t1_irq_early", 32'(irq), 0);
    step();
    grant("t1", 4'd0, 32'h100);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t1_irq_low", 32'(irq), 0);
    chk("t1_active", 32'(irq_active), 1);
    rd(2'd2, d); chk("t1_pend_clr", 32'(d), 0);
    rd(2'd3, d); chk("t1_stat", 32'(d), 32'h10);
    eret_ack = 1'b1; step(); eret_ack = 1'b0;
    chk("t1_eret", 32'(irq_active), 0);

    // T2: level sources 3 and 5
    irq_src = 8'h28;
    step();
    step();
    grant("t2a", 4'd3, 32'h10C);
    irq_src = 8'h20;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    eret_ack = 1'b1; step(); eret_ack = 1'b0;
    chk("t2_idle", 32'(irq), 0);
    step();
    grant("t2b", 4'd5, 32'h114);
    irq_src = 8'h00;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    eret_ack = 1'b1; step(); eret_ack = 1'b0;

    // T3: no preemption while in REQ
    irq_src = 8'h10;
    step();
    step();
    grant("t3a", 4'd4, 32'h110);
    irq_src = 8'h02;
    step();
    chk("t3_hold1", 32'(irq_id), 4);
    step();
    chk("t3_hold2", 32'(irq_id), 4);
    chk("t3_hold_irq", 32'(irq), 1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t3_act_id", 32'(irq_id), 4);
    chk("t3_act", 32'(irq_active), 1);
    chk("t3_act_irq", 32'(irq), 0);
    eret_ack = 1'b1; step(); eret_ack = 1'b0;
    step();
    grant("t3b", 4'd1, 32'h104);
    irq_src = 8'h00;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    eret_ack = 1'b1; step(); eret_ack = 1'b0;

    // T4: set beats ack clear on edge source 2
    wr(2'd1, 16'h0005);
    irq_src = 8'h04;
    step();
    irq_src = 8'h00;
    step();
    grant("t4a", 4'd2, 32'h108);
    irq_src = 8'h04;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_src = 8'h00;
    rd(2'd2, d); chk("t4_pend_kept", 32'(d), 32'h04);
    chk("t4_active", 32'(irq_active), 1);
    eret_ack = 1'b1; step(); eret_ack = 1'b0;
    step();
    grant("t4b", 4'd2, 32'h108);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    rd(2'd2, d); chk("t4_pend_clr", 32'(d), 0);
    eret_ack = 1'b1; step(); eret_ack = 1'b0;

    // T5: masked source then unmask
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'h0045);
    irq_src = 8'h40;
    step();
    irq_src = 8'h00;
    step();
    step();
    chk("t5_masked_irq", 32'(irq), 0);
    rd(2'd2, d); chk("t5_pend", 32'(d), 32'h40);
    wr(2'd0, 16'h0040);
    step();
    grant("t5", 4'd6, 32'h118);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t5_active", 32'(irq_active), 1);

    // T6: reset mid-ISR with pending work
    wr(2'd2, 16'h000A);
    rd(2'd2, d); chk("t6_pend_sw", 32'(d), 32'h0A);
    chk("t6_still_act", 32'(irq_active), 1);
    wr(2'd3, 16'hFFFF);
    rd(2'd3, d); chk("t6_stat_ro", 32'(d), 32'h16);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_active", 32'(irq_active), 0);
    chk("t6_irq", 32'(irq), 0);
    rd(2'd2, d); chk("t6_pend", 32'(d), 0);
    rd(2'd0, d); chk("t6_en", 32'(d), 0);
    eret_ack = 1'b1; step(); eret_ack = 1'b0;
    chk("t6_eret_irq", 32'(irq), 0);
    chk("t6_eret_act", 32'(irq_active), 0);
    step();
    chk("t6_quiet", 32'(irq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
